// File: rtl/snake_sprite_row_fetcher.sv
// Sprite row fetcher: an Avalon-MM read master that pulls one 16-pixel row out of
// the sprite ROM into one of two ping-pong buffers while the other buffer drains
// as a valid/ready pixel stream. Mirroring is resolved on the address side, so a
// stored row is always already in emission order.
module snake_sprite_row_fetcher #(
    parameter int unsigned ROM_AW = 8,
    parameter int unsigned PIX_W  = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    // Row request
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [3:0]        req_row,
    input  logic              req_mirror,
    // Sprite ROM read port
    output logic [ROM_AW-1:0] rom_address,
    output logic              rom_chipselect,
    output logic              rom_clken,
    input  logic [PIX_W-1:0]  rom_readdata,
    // Pixel stream
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic [PIX_W-1:0]  pix_data,
    output logic              pix_last,
    output logic              busy
);

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait
    } state_e;

    // Fetch side
    state_e           state_q;
    logic [3:0]       row_q;
    logic             mirror_q;
    logic [3:0]       k_q;
    logic             rom_cs_q;
    logic             wr_sel_q;

    // One-cycle capture pipeline: readdata for slot k arrives the cycle after slot k
    logic             cap_valid_q;
    logic [3:0]       cap_k_q;

    // Drain side
    logic             rd_sel_q;
    logic [3:0]       idx_q;
    logic [1:0]       full_q;
    logic [1:0]       full_d;

    logic [PIX_W-1:0] row_buf_q [2][16];

    logic             accept;
    logic             fill_done;
    logic             drain_step;
    logic             drain_done;

    // Column for issue slot k; mirrored rows walk the ROM backwards
    function automatic logic [3:0] slot_col(input logic mir, input logic [3:0] k);
        return mir ? (4'd15 - k) : k;
    endfunction

    assign accept     = req_valid && req_ready;
    assign fill_done  = (state_q == StWait);
    assign drain_step = pix_valid && pix_ready;
    assign drain_done = drain_step && (idx_q == 4'd15);

    // Request acceptance depends only on registered state, never on req_valid
    always_comb begin
        req_ready = (state_q == StIdle) && !full_q[wr_sel_q];
    end

    // Fetch FSM with registered ROM address and chip select
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            row_q       <= 4'd0;
            mirror_q    <= 1'b0;
            k_q         <= 4'd0;
            rom_address <= '0;
            rom_cs_q    <= 1'b0;
            cap_valid_q <= 1'b0;
            cap_k_q     <= 4'd0;
            wr_sel_q    <= 1'b0;
        end else begin
            cap_valid_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        row_q       <= req_row;
                        mirror_q    <= req_mirror;
                        k_q         <= 4'd0;
                        rom_address <= ROM_AW'({req_row, slot_col(req_mirror, 4'd0)});
                        rom_cs_q    <= 1'b1;
                        state_q     <= StIssue;
                    end
                end
                StIssue: begin
                    // The address for slot k is on the bus this cycle; its data
                    // returns next cycle
                    cap_valid_q <= 1'b1;
                    cap_k_q     <= k_q;
                    if (k_q == 4'd15) begin
                        // Address is left as-is so the bus stays quiet
                        rom_cs_q <= 1'b0;
                        state_q  <= StWait;
                    end else begin
                        k_q         <= k_q + 4'd1;
                        rom_address <= ROM_AW'({row_q, slot_col(mirror_q, k_q + 4'd1)});
                    end
                end
                StWait: begin
                    // Final word is captured on this edge; next fill goes to the
                    // other buffer
                    wr_sel_q <= ~wr_sel_q;
                    state_q  <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // Write returning ROM words into the buffer being filled, indexed by slot
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int b = 0; b < 2; b++) begin
                for (int i = 0; i < 16; i++) begin
                    row_buf_q[b][i] <= '0;
                end
            end
        end else if (cap_valid_q) begin
            row_buf_q[wr_sel_q][cap_k_q] <= rom_readdata;
        end
    end

    // Full flags: fill sets wr_sel, drain clears rd_sel; both may land on one edge
    always_comb begin
        full_d = full_q;
        if (drain_done) begin
            full_d[rd_sel_q] = 1'b0;
        end
        if (fill_done) begin
            full_d[wr_sel_q] = 1'b1;
        end
    end

    // Drain pointer and buffer flags
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            full_q   <= 2'b00;
            rd_sel_q <= 1'b0;
            idx_q    <= 4'd0;
        end else begin
            full_q <= full_d;
            if (drain_step) begin
                if (idx_q == 4'd15) begin
                    idx_q    <= 4'd0;
                    rd_sel_q <= ~rd_sel_q;
                end else begin
                    idx_q <= idx_q + 4'd1;
                end
            end
        end
    end

    // Stream outputs come straight from registers, so they hold under backpressure
    always_comb begin
        pix_valid      = full_q[rd_sel_q];
        pix_data       = row_buf_q[rd_sel_q][idx_q];
        pix_last       = pix_valid && (idx_q == 4'd15);
        busy           = (state_q != StIdle) || (|full_q);
        rom_chipselect = rom_cs_q;
        rom_clken      = rom_cs_q;
    end

endmodule
